// File: rtl/tristate_sense_pkg.sv
// Shared level encodings, FSM states and sequence helpers for the tristate
// exerciser/sense pair.
package tristate_sense_pkg;

  localparam logic [1:0] LVL_LOW     = 2'b00;
  localparam logic [1:0] LVL_HIGH    = 2'b01;
  localparam logic [1:0] LVL_FLOAT   = 2'b10;
  localparam logic [1:0] LVL_UNKNOWN = 2'b11;

  typedef enum logic [2:0] {
    DRIVE_HI,
    SAMPLE_HI,
    DRIVE_LO,
    SAMPLE_LO,
    EVAL
  } state_t;

  // A pin that follows the probe is floating; one that disagrees with it is a glitch.
  function automatic logic [1:0] classify(input logic s_hi, input logic s_lo);
    case ({s_hi, s_lo})
      2'b00:   return LVL_LOW;
      2'b11:   return LVL_HIGH;
      2'b10:   return LVL_FLOAT;
      default: return LVL_UNKNOWN;
    endcase
  endfunction

  // LVL_UNKNOWN as a result means "either driven level is acceptable".
  function automatic logic [1:0] next_expected(input logic [1:0] last_driven,
                                               input logic [1:0] prev_level);
    if (prev_level == LVL_LOW || prev_level == LVL_HIGH)
      return LVL_FLOAT;
    else if (last_driven == LVL_LOW)
      return LVL_HIGH;
    else if (last_driven == LVL_HIGH)
      return LVL_LOW;
    else
      return LVL_UNKNOWN;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous active-low reset, for asynchronous pin inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tristate_sense.sv
// Weak-probe pin classifier: measures LOW/HIGH/FLOAT, debounces the result and
// checks the accepted levels against the exerciser's 0, Z, 1, Z pattern.
module tristate_sense
  import tristate_sense_pkg::*;
#(
  parameter int SETTLE    = 16,
  parameter int CONFIRM   = 3,
  parameter int ERR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pin_in,
  output logic                 probe,
  output logic [1:0]           level,
  output logic                 changed,
  output logic                 seq_error,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 locked
);

  localparam int SW = $clog2(SETTLE);
  localparam int CW = $clog2(CONFIRM + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [CW-1:0] CONFIRM_N   = CW'(CONFIRM);

  logic          pin_s;
  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] conf_cnt;
  logic [CW-1:0] conf_next;
  logic [1:0]    prev_cand;
  logic [1:0]    last_driven;
  logic [1:0]    cand;
  logic [1:0]    expected;
  logic          cand_driven;
  logic          accept;
  logic          violation;
  logic          s_hi;
  logic          s_lo;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pin_in),
    .q     (pin_s)
  );

  always_comb begin
    cand        = classify(s_hi, s_lo);
    cand_driven = (cand == LVL_LOW) || (cand == LVL_HIGH);
    conf_next   = CW'(1);
    if (cand == LVL_UNKNOWN)
      conf_next = '0;
    else if (cand == prev_cand)
      conf_next = (conf_cnt == CONFIRM_N) ? conf_cnt : conf_cnt + 1'b1;
    accept    = (conf_next == CONFIRM_N) && (cand != level);
    expected  = next_expected(last_driven, level);
    violation = !((cand == expected) || (expected == LVL_UNKNOWN && cand_driven));
  end

  // Probe samples are plain data; reset only restarts the measurement around them.
  always_ff @(posedge clk) begin
    if (state == SAMPLE_HI) s_hi <= pin_s;
    if (state == SAMPLE_LO) s_lo <= pin_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= DRIVE_HI;
      settle_cnt  <= '0;
      probe       <= 1'b1;
      conf_cnt    <= '0;
      prev_cand   <= LVL_UNKNOWN;
      last_driven <= LVL_UNKNOWN;
      level       <= LVL_UNKNOWN;
      changed     <= 1'b0;
      seq_error   <= 1'b0;
      err_count   <= '0;
      locked      <= 1'b0;
    end else begin
      changed   <= 1'b0;
      seq_error <= 1'b0;
      case (state)
        DRIVE_HI: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= SAMPLE_HI;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE_HI: begin
          probe <= 1'b0;
          state <= DRIVE_LO;
        end
        DRIVE_LO: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= SAMPLE_LO;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE_LO: state <= EVAL;
        EVAL: begin
          probe     <= 1'b1;
          state     <= DRIVE_HI;
          conf_cnt  <= conf_next;
          prev_cand <= cand;
          if (accept) begin
            level   <= cand;
            changed <= 1'b1;
            if (cand_driven) last_driven <= cand;
            if (!locked) begin
              locked <= 1'b1;
            end else if (violation) begin
              seq_error <= 1'b1;
              if (err_count != '1) err_count <= err_count + 1'b1;
            end
          end
        end
        default: begin
          state      <= DRIVE_HI;
          settle_cnt <= '0;
          probe      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_sense.sv
// Bench for tristate_sense: resistive pin model plus a phase-level reference of
// the accepted-level sequence and its violation rules.
module tb_tristate_sense;

  localparam int SETTLE    = 4;
  localparam int CONFIRM   = 2;
  localparam int ERR_WIDTH = 8;
  localparam int ERR_MAX   = (1 << ERR_WIDTH) - 1;
  localparam logic [1:0] L_LOW = 2'b00, L_HIGH = 2'b01, L_FLOAT = 2'b10, L_UNK = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drv_en = 1'b0;
  logic drv_val = 1'b0;
  logic pin_in, probe, changed, seq_error, locked;
  logic [1:0] level;
  logic [ERR_WIDTH-1:0] err_count;

  int n_checks = 0, n_fail = 0;
  int n_changed = 0, n_seqerr = 0;

  logic [1:0] m_level, m_last;
  logic       m_locked, m_has_last;
  int         m_err, exp_chg, exp_err;

  assign pin_in = drv_en ? drv_val : probe;
  always #5 clk = ~clk;

  tristate_sense #(.SETTLE(SETTLE), .CONFIRM(CONFIRM), .ERR_WIDTH(ERR_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pin_in    (pin_in),
    .probe     (probe),
    .level     (level),
    .changed   (changed),
    .seq_error (seq_error),
    .err_count (err_count),
    .locked    (locked)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (changed === 1'b1) n_changed++;
      if (seq_error === 1'b1) n_seqerr++;
    end
  end

  task automatic model_reset();
    m_level = L_UNK; m_last = L_UNK; m_locked = 1'b0; m_has_last = 1'b0; m_err = 0;
  endtask

  // Pattern rules: driven levels alternate with FLOAT, and successive driven levels alternate.
  function automatic void model_step(input logic [1:0] cls);
    logic bad;
    exp_chg = 0; exp_err = 0; bad = 1'b0;
    if (cls != m_level) begin
      exp_chg = 1;
      if (!m_locked) m_locked = 1'b1;
      else if (cls == L_FLOAT) bad = !(m_level == L_LOW || m_level == L_HIGH);
      else bad = (m_level == L_LOW || m_level == L_HIGH) || (m_has_last && cls == m_last);
      if (bad) begin
        exp_err = 1;
        if (m_err < ERR_MAX) m_err++;
      end
      if (cls != L_FLOAT) begin m_last = cls; m_has_last = 1'b1; end
      m_level = cls;
    end
  endfunction

  task automatic run_phase(input logic en, input logic val, input int hold, input string tag);
    int c0, e0;
    c0 = n_changed; e0 = n_seqerr;
    drv_en = en; drv_val = val;
    model_step(en ? (val ? L_HIGH : L_LOW) : L_FLOAT);
    repeat (hold) @(negedge clk);
    n_checks++;
    if (level !== m_level) begin n_fail++; $display("FAIL %s level: got %b expected %b", tag, level, m_level); end
    n_checks++;
    if (n_changed - c0 !== exp_chg) begin n_fail++; $display("FAIL %s changed pulses: got %0d expected %0d", tag, n_changed - c0, exp_chg); end
    n_checks++;
    if (n_seqerr - e0 !== exp_err) begin n_fail++; $display("FAIL %s seq_error pulses: got %0d expected %0d", tag, n_seqerr - e0, exp_err); end
    n_checks++;
    if (err_count !== ERR_WIDTH'(m_err)) begin n_fail++; $display("FAIL %s err_count: got %0d expected %0d", tag, err_count, m_err); end
  endtask

  task automatic wait_probe(input logic val, output logic ok);
    int t = 0;
    while (probe !== val && t < 100) begin @(negedge clk); t++; end
    ok = (probe === val);
  endtask

  task automatic test_reset();
    drv_en = 1'b0; rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++; if (probe !== 1'b1) begin n_fail++; $display("FAIL reset probe: got %b expected 1", probe); end
    n_checks++; if (level !== L_UNK) begin n_fail++; $display("FAIL reset level: got %b expected 11", level); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset locked: got %b expected 0", locked); end
    n_checks++; if (err_count !== '0) begin n_fail++; $display("FAIL reset err_count: got %0d expected 0", err_count); end
    n_checks++; if (changed !== 1'b0 || seq_error !== 1'b0) begin n_fail++; $display("FAIL reset pulses: got %b%b expected 00", changed, seq_error); end
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++; if (probe !== 1'b1) begin n_fail++; $display("FAIL first drive_hi cycle %0d probe: got %b expected 1", i, probe); end
    end
    @(negedge clk);
    n_checks++; if (probe !== 1'b0) begin n_fail++; $display("FAIL first drive_lo probe: got %b expected 0", probe); end
  endtask

  task automatic test_float();
    repeat (16) @(negedge clk);
    n_checks++; if (level !== L_UNK) begin n_fail++; $display("FAIL float early level: got %b expected 11", level); end
    @(negedge clk);
    model_step(L_FLOAT);
    n_checks++; if (level !== L_FLOAT) begin n_fail++; $display("FAIL float level: got %b expected 10", level); end
    n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL float changed: got %b expected 1", changed); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL float locked: got %b expected 1", locked); end
    n_checks++; if (seq_error !== 1'b0) begin n_fail++; $display("FAIL float seq_error: got %b expected 0", seq_error); end
    @(negedge clk);
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL float changed width: got %b expected 0", changed); end
  endtask

  task automatic test_legal();
    int c0 = n_changed;
    run_phase(1'b1, 1'b0, 200, "legal_0");
    run_phase(1'b0, 1'b0, 200, "legal_z1");
    run_phase(1'b1, 1'b1, 200, "legal_1");
    run_phase(1'b0, 1'b0, 200, "legal_z2");
    run_phase(1'b1, 1'b0, 200, "legal_0b");
    n_checks++; if (n_changed - c0 !== 5) begin n_fail++; $display("FAIL legal total changes: got %0d expected 5", n_changed - c0); end
    n_checks++; if (err_count !== 0) begin n_fail++; $display("FAIL legal err_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_illegal();
    run_phase(1'b1, 1'b1, 100, "jump_hi");
    n_checks++; if (err_count !== 1) begin n_fail++; $display("FAIL jump err_count: got %0d expected 1", err_count); end
    run_phase(1'b0, 1'b0, 100, "jump_z");
    run_phase(1'b1, 1'b1, 100, "repeat_hi");
    n_checks++; if (err_count !== 2) begin n_fail++; $display("FAIL repeat err_count: got %0d expected 2", err_count); end
  endtask

  task automatic test_glitch();
    int c0, e0;
    logic ok, ok2;
    run_phase(1'b0, 1'b0, 100, "glitch_z");
    run_phase(1'b1, 1'b0, 100, "glitch_low");
    wait_probe(1'b0, ok);
    wait_probe(1'b1, ok2);
    n_checks++;
    if (!(ok && ok2)) begin n_fail++; $display("FAIL glitch probe alignment: got timeout expected probe edge"); end
    c0 = n_changed; e0 = n_seqerr;
    drv_val = 1'b1;
    repeat (11) @(negedge clk);
    drv_val = 1'b0;
    repeat (60) @(negedge clk);
    n_checks++; if (level !== L_LOW) begin n_fail++; $display("FAIL glitch level: got %b expected 00", level); end
    n_checks++; if (n_changed !== c0 || n_seqerr !== e0) begin n_fail++; $display("FAIL glitch pulses: got %0d/%0d expected 0/0", n_changed - c0, n_seqerr - e0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      int r = $urandom_range(0, 2);
      run_phase(r != 2, r == 1, $urandom_range(45, 120), $sformatf("random_%0d", i));
    end
  endtask

  task automatic test_saturation();
    int e0;
    run_phase(1'b1, 1'b0, 60, "sat_start");
    e0 = n_seqerr;
    for (int i = 0; i < 300; i++) run_phase(1'b1, (i % 2) == 0, 44, $sformatf("sat_%0d", i));
    n_checks++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL saturation err_count: got %0d expected 255", err_count); end
    n_checks++; if (n_seqerr - e0 !== 300) begin n_fail++; $display("FAIL saturation pulses: got %0d expected 300", n_seqerr - e0); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    wait_probe(1'b1, ok);
    wait_probe(1'b0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_mid probe alignment: got timeout expected probe fall"); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (probe !== 1'b1) begin n_fail++; $display("FAIL reset_mid probe: got %b expected 1", probe); end
    n_checks++; if (level !== L_UNK) begin n_fail++; $display("FAIL reset_mid level: got %b expected 11", level); end
    n_checks++; if (err_count !== 0) begin n_fail++; $display("FAIL reset_mid err_count: got %0d expected 0", err_count); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_mid locked: got %b expected 0", locked); end
    n_checks++; if (changed !== 1'b0 || seq_error !== 1'b0) begin n_fail++; $display("FAIL reset_mid pulses: got %b%b expected 00", changed, seq_error); end
    rst_n = 1'b1;
    model_reset();
    run_phase(1'b0, 1'b0, 60, "post_reset");
  endtask

  initial begin
    model_reset();
    exp_chg = 0; exp_err = 0;
    test_reset();
    test_float();
    test_legal();
    test_illegal();
    test_glitch();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tristate_sense.md
Name: tristate_sense

Overview:
- Receive-side counterpart of the tristate pin exerciser.
- Classifies an external pin as driven-low, driven-high or floating by toggling a weak probe output onto the same net through a high-value resistor, and sampling the pin level after each probe phase.
- Debounces the classification.
- Checks the received level sequence against the exerciser pattern (0, Z, 1, Z, ...) and counts violations.
- Sits on the observing board or FPGA, with the pin driven by the unit under test.

Parameters:
SETTLE, 16, cycles the probe is held at each level before sampling; minimum 3, to cover the 2-flop synchronizer.
CONFIRM, 3, consecutive identical measurements required to accept a new level; minimum 1.
ERR_WIDTH, 8, width of the saturating sequence error counter.

Ports:
clk  input  1  system clock; single clock domain.
rst_n  input  1  reset, synchronous, active-low.
pin_in  input  1  raw asynchronous pin level.
probe  output  1  weak probe drive, to the pin via an external resistor.
level  output  2  accepted classification: 00 LOW, 01 HIGH, 10 FLOAT, 11 UNKNOWN.
changed  output  1  one-cycle pulse when level updates.
seq_error  output  1  one-cycle pulse on a sequence violation.
err_count  output  ERR_WIDTH  saturating count of violations.
locked  output  1  first valid level has been accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge), with reset values:
  - probe=1, level=11, changed=0, seq_error=0, err_count=0, locked=0.
  - FSM returns to DRIVE_HI; settle counter, confirm counter and last_driven are cleared.
  - Synchronizer flops reset to 0.
  - Reset mid-measurement discards the partial measurement.
- pin_in passes through a 2-flop synchronizer; pin_s is the synchronized level.
- FSM states and timing, one measurement every 2*SETTLE+3 cycles:
  - DRIVE_HI: probe=1 for SETTLE cycles.
  - SAMPLE_HI: 1 cycle; captures s_hi=pin_s.
  - DRIVE_LO: probe=0 for SETTLE cycles.
  - SAMPLE_LO: 1 cycle; captures s_lo=pin_s.
  - EVAL: 1 cycle; probe=0; classifies, then returns to DRIVE_HI.
- Classification as (s_hi, s_lo) -> candidate:
  - (0,0) -> LOW.
  - (1,1) -> HIGH.
  - (1,0) -> FLOAT, because the pin followed the probe.
  - (0,1) -> UNKNOWN, a contradictory glitch.
- Confirm logic, evaluated in EVAL:
  - If candidate equals the previous candidate, the confirm counter increments, saturating at CONFIRM.
  - Otherwise the confirm counter is set to 1.
  - An UNKNOWN candidate always clears the confirm counter to 0 and is never accepted.
- Acceptance:
  - Occurs when the confirm counter reaches CONFIRM and candidate != level.
  - On the cycle after EVAL: level <= candidate; changed pulses.
  - The same cycle also performs the sequence check.
- Sequence check, on each accepted change:
  - If locked=0: accept without error; set locked=1.
  - LOW or HIGH: the previous level must have been FLOAT or UNKNOWN. The new level must be the opposite of last_driven, unless last_driven is unset.
  - FLOAT: the previous level must have been LOW or HIGH.
  - last_driven is updated whenever LOW or HIGH is accepted.
  - LOW -> HIGH directly (and vice versa) is always a violation.
  - A violation pulses seq_error and increments err_count, saturating at all-ones with no wrap.
  - level still updates on a violation.
- A steady level produces no changed pulses, however long it persists.
- Latency: a pin change is reflected in level within (CONFIRM+1)*(2*SETTLE+3)+3 cycles.

Decomposition:
- Shared package holds:
  - level encodings LVL_LOW, LVL_HIGH, LVL_FLOAT, LVL_UNKNOWN;
  - FSM state enum;
  - a function next_expected(last_driven, prev_level).
- The exerciser uses the same encodings for pattern generation.
- One sub-module: sync_2ff (parameterless 2-flop synchronizer with reset), reused for other pin inputs.
- FSM, confirm logic and checker live in tristate_sense.

Test Plan:
- Bench pin model: pin = drv_en ? drv_val : probe. All scenarios use SETTLE=4 and CONFIRM=2.
- Reset: hold rst_n=0 for 5 cycles with pin floating -> probe=1, level=11, locked=0, err_count=0. After release, first DRIVE_HI lasts 4 cycles.
- Floating pin: drv_en=0 -> after 2 measurements (22 cycles), level=10, changed pulses once, locked=1, seq_error=0.
- Legal pattern: drive 0, Z, 1, Z, 0 with each phase held 200 cycles -> level follows 00, 10, 01, 10, 00 with 5 changed pulses and err_count=0.
- Illegal jump: after locked LOW, drive 1 directly -> level=01, seq_error pulses, err_count=1. Then Z followed by 1 (not the opposite of HIGH) -> err_count=2.
- Glitch rejection: toggle drv_val so that a single measurement reads HIGH between LOW measurements -> level stays 00 and no changed pulse.
- Saturation and reset: force 300 violations with ERR_WIDTH=8 -> err_count holds at 255. Assert rst_n=0 mid-DRIVE_LO -> all outputs return to reset values on the next edge.
